// File: rtl/robot_sensor_scan.sv
// Sensor scan stage for the robot FSM: reads own/front/left map cells and
// produces head/left/barrier/under flags with a fixed 4-cycle latency.
//
// Ports:
//   clock_50, reset_key        clock and synchronous active-low reset
//   start                      scan request, sampled only while idle
//   robot_row/column/orient.   robot pose captured when a scan is accepted
//   map_rd_en/row/column       synchronous map read request
//   map_data                   cell code, valid the cycle after the request
//   head/left/barrier/under    sensor flags, held between scans
//   sensors_valid              one-cycle pulse after the flags update
//   busy                       scan in progress
module robot_sensor_scan #(
  parameter int ROWS = 10,
  parameter int COLS = 20
) (
  input  logic       clock_50,
  input  logic       reset_key,
  input  logic       start,
  input  logic [3:0] robot_row,
  input  logic [4:0] robot_column,
  input  logic [3:0] robot_orientation,
  output logic       map_rd_en,
  output logic [3:0] map_row,
  output logic [4:0] map_column,
  input  logic [2:0] map_data,
  output logic       head,
  output logic       left,
  output logic       barrier,
  output logic       under,
  output logic       sensors_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_UNDER,
    RD_HEAD,
    RD_LEFT,
    CAPTURE
  } state_t;

  typedef enum logic [1:0] {
    DIR_N,
    DIR_S,
    DIR_E,
    DIR_W
  } dir_t;

  localparam logic [4:0] ROW_MAX = 5'(ROWS);
  localparam logic [5:0] COL_MAX = 6'(COLS);
  localparam logic [2:0] C_WALL  = 3'b001;

  state_t     state;
  dir_t       req_dir;
  logic [4:0] req_row;
  logic [5:0] req_col;
  logic [2:0] own_code;
  logic [2:0] front_code;
  logic       pend_off;

  dir_t       dir_in;
  logic [4:0] front_r;
  logic [5:0] front_c;
  logic [4:0] left_r;
  logic [5:0] left_c;
  logic [4:0] addr_r;
  logic [5:0] addr_c;
  logic       addr_go;
  logic       on_map;
  logic       rd_next;
  logic [2:0] code_in;

  function automatic logic is_trash(input logic [2:0] code);
    return (code == 3'b010) || (code == 3'b011) || (code == 3'b100);
  endfunction

  // Unused orientation codes fall back to north.
  always_comb begin
    dir_in = DIR_N;
    if (robot_orientation[3:2] == 2'b00) begin
      dir_in = dir_t'(robot_orientation[1:0]);
    end
  end

  // One guard bit: 0-1 wraps to all ones, which is beyond the map
  // and therefore off-map, same as row/col 0 or ROWS+1/COLS+1.
  always_comb begin
    front_r = req_row;
    front_c = req_col;
    left_r  = req_row;
    left_c  = req_col;
    unique case (req_dir)
      DIR_N: begin
        front_r = req_row - 5'd1;
        left_c  = req_col - 6'd1;
      end
      DIR_S: begin
        front_r = req_row + 5'd1;
        left_c  = req_col + 6'd1;
      end
      DIR_E: begin
        front_c = req_col + 6'd1;
        left_r  = req_row - 5'd1;
      end
      DIR_W: begin
        front_c = req_col - 6'd1;
        left_r  = req_row + 5'd1;
      end
    endcase
  end

  // Address for the state being entered; the own cell comes straight
  // from the inputs because it is latched on the same edge.
  always_comb begin
    addr_r  = '0;
    addr_c  = '0;
    addr_go = 1'b0;
    unique case (state)
      IDLE: begin
        addr_r  = {1'b0, robot_row};
        addr_c  = {1'b0, robot_column};
        addr_go = start;
      end
      RD_UNDER: begin
        addr_r  = front_r;
        addr_c  = front_c;
        addr_go = 1'b1;
      end
      RD_HEAD: begin
        addr_r  = left_r;
        addr_c  = left_c;
        addr_go = 1'b1;
      end
      default: begin
        addr_go = 1'b0;
      end
    endcase
  end

  assign on_map = (addr_r != '0) && (addr_r <= ROW_MAX)
               && (addr_c != '0) && (addr_c <= COL_MAX);
  assign rd_next = addr_go && on_map;

  // A read that was suppressed as off-map reads back as a wall.
  assign code_in = pend_off ? C_WALL : map_data;

  always_ff @(posedge clock_50) begin
    if (!reset_key) begin
      state         <= IDLE;
      req_dir       <= DIR_N;
      req_row       <= '0;
      req_col       <= '0;
      own_code      <= '0;
      front_code    <= '0;
      pend_off      <= 1'b0;
      map_rd_en     <= 1'b0;
      map_row       <= '0;
      map_column    <= '0;
      head          <= 1'b0;
      left          <= 1'b0;
      barrier       <= 1'b0;
      under         <= 1'b0;
      sensors_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sensors_valid <= 1'b0;
      map_rd_en     <= rd_next;
      map_row       <= rd_next ? addr_r[3:0] : 4'd0;
      map_column    <= rd_next ? addr_c[4:0] : 5'd0;
      pend_off      <= ~map_rd_en;
      unique case (state)
        IDLE: begin
          if (start) begin
            req_row <= {1'b0, robot_row};
            req_col <= {1'b0, robot_column};
            req_dir <= dir_in;
            busy    <= 1'b1;
            state   <= RD_UNDER;
          end
        end
        RD_UNDER: begin
          state <= RD_HEAD;
        end
        RD_HEAD: begin
          own_code <= code_in;
          state    <= RD_LEFT;
        end
        RD_LEFT: begin
          front_code <= code_in;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          under         <= is_trash(own_code);
          head          <= (front_code == C_WALL);
          barrier       <= is_trash(front_code);
          left          <= (code_in == C_WALL);
          sensors_valid <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robot_sensor_scan.sv
// Testbench for robot_sensor_scan: directed scans, scoreboard monitor
// checks map reads and flag results against hand-computed expectations.
module tb_robot_sensor_scan;

  logic       clk;
  logic       reset_key;
  logic       start;
  logic [3:0] robot_row;
  logic [4:0] robot_column;
  logic [3:0] robot_orientation;
  logic       map_rd_en;
  logic [3:0] map_row;
  logic [4:0] map_column;
  logic [2:0] map_data;
  logic       head;
  logic       left;
  logic       barrier;
  logic       under;
  logic       sensors_valid;
  logic       busy;

  robot_sensor_scan #(.ROWS(10), .COLS(20)) dut (
    .clock_50(clk),
    .reset_key(reset_key),
    .start(start),
    .robot_row(robot_row),
    .robot_column(robot_column),
    .robot_orientation(robot_orientation),
    .map_rd_en(map_rd_en),
    .map_row(map_row),
    .map_column(map_column),
    .map_data(map_data),
    .head(head),
    .left(left),
    .barrier(barrier),
    .under(under),
    .sensors_valid(sensors_valid),
    .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic [3:0] row;
    logic [4:0] col;
  } rd_t;

  typedef struct {
    int         cyc;
    logic [3:0] f;
  } fl_t;

  rd_t rd_q[$];
  fl_t fl_q[$];

  logic [2:0] mem [0:15][0:31];
  int cyc = 0;
  int base = 0;
  int n_checks = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (map_rd_en === 1'b1) map_data <= mem[map_row][map_column];
  end

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a read or a result.
  always @(negedge clk) begin
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      chk("missed_read_cycle", 32'(cyc), 32'(rd_q[0].cyc));
      void'(rd_q.pop_front());
    end
    if (map_rd_en === 1'b1) begin
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        chk("read_row", 32'(map_row), 32'(rd_q[0].row));
        chk("read_col", 32'(map_column), 32'(rd_q[0].col));
        void'(rd_q.pop_front());
      end else begin
        chk("unexpected_read", 32'(1), 32'(0));
      end
    end
    while (fl_q.size() > 0 && fl_q[0].cyc < cyc) begin
      chk("missed_valid_cycle", 32'(cyc), 32'(fl_q[0].cyc));
      void'(fl_q.pop_front());
    end
    if (sensors_valid === 1'b1) begin
      if (fl_q.size() > 0 && fl_q[0].cyc == cyc) begin
        chk("flags_hlbu", 32'({head, left, barrier, under}),
            32'(fl_q[0].f));
        void'(fl_q.pop_front());
      end else begin
        chk("unexpected_valid", 32'(1), 32'(0));
      end
    end
  end

  task automatic exp_rd(input int c, input int r, input int col);
    rd_t e;
    e.cyc = c;
    e.row = 4'(r);
    e.col = 5'(col);
    rd_q.push_back(e);
  endtask

  task automatic exp_fl(input int c, input logic [3:0] f);
    fl_t e;
    e.cyc = c;
    e.f = f;
    fl_q.push_back(e);
  endtask

  // Call at a negedge: drives the request and records the base cycle.
  task automatic go(input int r, input int c, input logic [3:0] o);
    robot_row = 4'(r);
    robot_column = 5'(c);
    robot_orientation = o;
    start = 1'b1;
    base = cyc;
  endtask

  task automatic drain();
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 32; j++)
        mem[i][j] = 3'b000;
    mem[5][10] = 3'b011;
    mem[10][19] = 3'b100;
    mem[3][3] = 3'b111;
    mem[4][3] = 3'b001;
    mem[3][4] = 3'b001;
    mem[2][5] = 3'b100;
    mem[1][5] = 3'b010;
    mem[2][4] = 3'b010;
    map_data = 3'b000;
    reset_key = 1'b0;
    start = 1'b0;
    robot_row = 4'd0;
    robot_column = 5'd0;
    robot_orientation = 4'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_head", 32'(head), 0);
    chk("rst_left", 32'(left), 0);
    chk("rst_barrier", 32'(barrier), 0);
    chk("rst_under", 32'(under), 0);
    chk("rst_valid", 32'(sensors_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(map_rd_en), 0);
    chk("rst_addr", 32'({map_row, map_column}), 0);
    reset_key = 1'b1;
    repeat (20) @(negedge clk);

    // Open floor, east
    go(5, 10, 4'b0010);
    exp_rd(base + 1, 5, 10);
    exp_rd(base + 2, 5, 11);
    exp_rd(base + 3, 4, 10);
    exp_fl(base + 5, 4'b0001);
    drain();

    // Corner, north: front and left off-map
    go(1, 1, 4'b0000);
    exp_rd(base + 1, 1, 1);
    exp_fl(base + 5, 4'b1100);
    drain();

    // Trash ahead, wall (off-map) left, west
    go(10, 20, 4'b0011);
    exp_rd(base + 1, 10, 20);
    exp_rd(base + 2, 10, 19);
    exp_fl(base + 5, 4'b0110);
    drain();

    // South, walls ahead and left, own code 111 reads as empty
    go(3, 3, 4'b0001);
    exp_rd(base + 1, 3, 3);
    exp_rd(base + 2, 4, 3);
    exp_rd(base + 3, 3, 4);
    exp_fl(base + 5, 4'b1100);
    drain();

    // Unused orientation acts as north
    go(2, 5, 4'b1010);
    exp_rd(base + 1, 2, 5);
    exp_rd(base + 2, 1, 5);
    exp_rd(base + 3, 2, 4);
    exp_fl(base + 5, 4'b0011);
    drain();

    // Busy: extra start pulses ignored, pose changes ignored
    go(5, 10, 4'b0010);
    exp_rd(base + 1, 5, 10);
    exp_rd(base + 2, 5, 11);
    exp_rd(base + 3, 4, 10);
    exp_fl(base + 5, 4'b0001);
    @(negedge clk);
    start = 1'b0;
    robot_row = 4'd7;
    chk("busy_in_scan", 32'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_after_scan", 32'(busy), 0);

    // Held start: back-to-back scans every 5 cycles
    go(5, 10, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      exp_rd(base + 5 * k + 1, 5, 10);
      exp_rd(base + 5 * k + 2, 5, 11);
      exp_rd(base + 5 * k + 3, 4, 10);
      exp_fl(base + 5 * k + 5, 4'b0001);
    end
    repeat (11) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Reset mid-scan during RD_LEFT
    go(5, 10, 4'b0010);
    exp_rd(base + 1, 5, 10);
    exp_rd(base + 2, 5, 11);
    exp_rd(base + 3, 4, 10);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_key = 1'b0;
    @(negedge clk);
    reset_key = 1'b1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_flags", 32'({head, left, barrier, under}), 0);
    chk("midrst_rd_en", 32'(map_rd_en), 0);
    repeat (6) @(negedge clk);
    chk("midrst_no_valid_flags", 32'(under), 0);

    // Full scan after reset
    go(1, 1, 4'b0000);
    exp_rd(base + 1, 1, 1);
    exp_fl(base + 5, 4'b1100);
    drain();

    // Reset and start on the same edge: reset wins
    reset_key = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 0);
    chk("rst_start_flags", 32'({head, left, barrier, under}), 0);
    reset_key = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);

    chk("rd_queue_empty", 32'(rd_q.size()), 0);
    chk("fl_queue_empty", 32'(fl_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
